// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous data memory.
// Each transaction walks IDLE -> ISSUE -> CAPTURE, so one access completes every three cycles.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [7:0]        cmd0,
    input  logic [7:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic [7:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        memCmd_q, memCmd_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              sel;
    logic [7:0]        selCmd;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              cmdValid;
    logic              cmdRead;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            cmd_q      <= 8'h00;
            memCmd_q   <= 8'h00;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            cmd_q      <= cmd_d;
            memCmd_q   <= memCmd_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // prio_q names the port that wins a tie; it flips to the other port once a transaction completes.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        cmd_d      = cmd_q;
        memCmd_d   = memCmd_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        sel        = 1'b0;
        selCmd     = 8'h00;
        selAddr    = '0;
        selWdata   = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel      = (req0 && req1) ? prio_q : req1;
                    selCmd   = sel ? cmd1 : cmd0;
                    selAddr  = sel ? addr1 : addr0;
                    selWdata = sel ? wdata1 : wdata0;
                    owner_d  = sel;
                    cmd_d    = selCmd;
                    // A NOP leaves the memory bus untouched so it keeps showing the last real access.
                    if (selCmd == CMD_READ || selCmd == CMD_WRITE) begin
                        memCmd_d   = selCmd;
                        memAddr_d  = selAddr;
                        memWdata_d = selWdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                prio_d = ~owner_q;
                if (cmd_q == CMD_READ) begin
                    if (owner_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmdValid = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
    assign cmdRead  = (state_q == CAPTURE) && (cmd_q == CMD_READ);

    assign mem_en    = (state_q == ISSUE) && cmdValid;
    assign mem_cmd   = memCmd_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

    assign ack0  = (state_q == CAPTURE) && !owner_q;
    assign ack1  = (state_q == CAPTURE) && owner_q;
    assign grant = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

    // Memory data only arrives during CAPTURE, so it is forwarded alongside ack and held afterwards.
    assign rdata0 = (cmdRead && !owner_q) ? mem_rdata : rdata0_q;
    assign rdata1 = (cmdRead && owner_q) ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous memory model behind the arbiter.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] cmd0 = 8'h00, cmd1 = 8'h00;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       mem_en;
    logic [7:0] mem_cmd, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [1:0] grant;

    logic [7:0] mem [256];

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_cmd(mem_cmd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_cmd == 8'h01) mem[mem_addr] <= mem_wdata;
            else                  mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic [7:0] c0, input logic [7:0] a0, input logic [7:0] w0,
                                 input logic r1, input logic [7:0] c1, input logic [7:0] a1, input logic [7:0] w1);
        req0 = r0; cmd0 = c0; addr0 = a0; wdata0 = w0;
        req1 = r1; cmd1 = c1; addr1 = a1; wdata1 = w1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;

        // Reset state
        tick(); tick();
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_ack0", 32'(ack0), 32'h0);
        checkOutput("rst_ack1", 32'(ack1), 32'h0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_mem_cmd", 32'(mem_cmd), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_rdata0", 32'(rdata0), 32'h0);
        checkOutput("rst_rdata1", 32'(rdata1), 32'h0);
        rst = 1'b1;
        tick(); tick();
        checkOutput("idle_grant", 32'(grant), 32'h0);
        checkOutput("idle_mem_en", 32'(mem_en), 32'h0);

        // Single read on port 0
        applyStimulus(1'b1, 8'h00, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("rd0_issue_en", 32'(mem_en), 32'h1);
        checkOutput("rd0_issue_addr", 32'(mem_addr), 32'h10);
        checkOutput("rd0_issue_cmd", 32'(mem_cmd), 32'h00);
        checkOutput("rd0_issue_grant", 32'(grant), 32'h1);
        checkOutput("rd0_issue_ack0", 32'(ack0), 32'h0);
        tick();
        checkOutput("rd0_cap_ack0", 32'(ack0), 32'h1);
        checkOutput("rd0_cap_ack1", 32'(ack1), 32'h0);
        checkOutput("rd0_cap_rdata0", 32'(rdata0), 32'hA5);
        checkOutput("rd0_cap_mem_en", 32'(mem_en), 32'h0);
        req0 = 1'b0;
        tick();
        checkOutput("rd0_done_ack0", 32'(ack0), 32'h0);
        checkOutput("rd0_done_grant", 32'(grant), 32'h0);
        checkOutput("rd0_hold_rdata0", 32'(rdata0), 32'hA5);

        // Write then read back on port 1
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h20, 8'h3C);
        tick();
        checkOutput("wr1_issue_en", 32'(mem_en), 32'h1);
        checkOutput("wr1_issue_cmd", 32'(mem_cmd), 32'h01);
        checkOutput("wr1_issue_addr", 32'(mem_addr), 32'h20);
        checkOutput("wr1_issue_wdata", 32'(mem_wdata), 32'h3C);
        checkOutput("wr1_issue_grant", 32'(grant), 32'h2);
        tick();
        checkOutput("wr1_cap_ack1", 32'(ack1), 32'h1);
        checkOutput("wr1_cap_ack0", 32'(ack0), 32'h0);
        checkOutput("wr1_cap_rdata1", 32'(rdata1), 32'h00);
        req1 = 1'b0;
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h20, 8'h00);
        tick();
        checkOutput("rd1_issue_en", 32'(mem_en), 32'h1);
        tick();
        checkOutput("rd1_cap_ack1", 32'(ack1), 32'h1);
        checkOutput("rd1_cap_rdata1", 32'(rdata1), 32'h3C);
        checkOutput("rd1_keep_rdata0", 32'(rdata0), 32'hA5);
        req1 = 1'b0;
        tick();
        checkOutput("rd1_hold_rdata1", 32'(rdata1), 32'h3C);

        // NOP on port 0: no strobe, ack at normal offset, bus holds last access
        applyStimulus(1'b1, 8'h05, 8'h33, 8'h99, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("nop_issue_en", 32'(mem_en), 32'h0);
        checkOutput("nop_issue_grant", 32'(grant), 32'h1);
        checkOutput("nop_hold_addr", 32'(mem_addr), 32'h20);
        tick();
        checkOutput("nop_cap_ack0", 32'(ack0), 32'h1);
        checkOutput("nop_cap_rdata0", 32'(rdata0), 32'hA5);
        req0 = 1'b0;
        tick();
        checkOutput("nop_done_ack0", 32'(ack0), 32'h0);

        // Early drop: req and operands change after latching
        applyStimulus(1'b1, 8'h00, 8'h10, 8'h11, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("drop_issue_en", 32'(mem_en), 32'h1);
        checkOutput("drop_issue_addr", 32'(mem_addr), 32'h10);
        applyStimulus(1'b0, 8'h01, 8'h55, 8'h77, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("drop_cap_ack0", 32'(ack0), 32'h1);
        checkOutput("drop_cap_rdata0", 32'(rdata0), 32'hA5);
        checkOutput("drop_cap_addr", 32'(mem_addr), 32'h10);
        checkOutput("drop_cap_wdata", 32'(mem_wdata), 32'h11);
        tick();
        checkOutput("drop_idle_grant", 32'(grant), 32'h0);

        // Port 0 was served last, so port 1 wins this tie; then reset aborts it
        applyStimulus(1'b1, 8'h00, 8'h10, 8'h00, 1'b1, 8'h00, 8'h20, 8'h00);
        tick();
        checkOutput("abort_issue_grant", 32'(grant), 32'h2);
        checkOutput("abort_issue_en", 32'(mem_en), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("abort_async_en", 32'(mem_en), 32'h1);
        checkOutput("abort_async_grant", 32'(grant), 32'h2);
        @(posedge clk); #1;
        checkOutput("abort_grant", 32'(grant), 32'h0);
        checkOutput("abort_mem_en", 32'(mem_en), 32'h0);
        checkOutput("abort_ack0", 32'(ack0), 32'h0);
        checkOutput("abort_ack1", 32'(ack1), 32'h0);
        checkOutput("abort_rdata1", 32'(rdata1), 32'h0);
        rst = 1'b1;

        // Both requests held continuously: port 0 first, then alternate every 3 cycles
        for (int cyc = 0; cyc < 12; cyc++) begin
            int phase;
            int owner;
            tick();
            phase = cyc % 3;
            owner = (cyc / 3) % 2;
            checkOutput($sformatf("rr_ack0_c%0d", cyc), 32'(ack0), 32'((phase == 1) && (owner == 0)));
            checkOutput($sformatf("rr_ack1_c%0d", cyc), 32'(ack1), 32'((phase == 1) && (owner == 1)));
            checkOutput($sformatf("rr_grant_c%0d", cyc), 32'(grant),
                        (phase == 2) ? 32'h0 : ((owner == 0) ? 32'h1 : 32'h2));
            checkOutput($sformatf("rr_en_c%0d", cyc), 32'(mem_en), 32'(phase == 0));
            if (phase == 1) begin
                if (owner == 0) checkOutput($sformatf("rr_rdata0_c%0d", cyc), 32'(rdata0), 32'hA5);
                else            checkOutput($sformatf("rr_rdata1_c%0d", cyc), 32'(rdata1), 32'h3C);
            end
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("final_grant", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
